imem_arbiter: RTL and testbench
===============================

// Module: imem_arbiter
// PURPOSE
// - Memory-controller end of the instruction-fetch protocol (iREN/iaddr -> iwait/iload).
// - Services instruction-cache misses from NCPUS caches, one at a time, round-robin.
// - Forwards each granted fetch to the shared RAM port.
// - Yields the RAM to the data side whenever dbusy is asserted at grant time.
// PARAMETERS
// - NCPUS     2    number of instruction-cache requesters (>=1)
// - TIMEOUT   255  max REQ cycles before err_timeout pulses; 0 disables the watchdog
// PORTS
// - CLK          in   1          clock, rising edge
// - nRST         in   1          reset: asynchronous, active-low
// - iREN         in   NCPUS      per-CPU fetch request; held high with iaddr stable until iwait[i]=0
// - iaddr        in   NCPUS*32   per-CPU word-aligned fetch address
// - iwait        out  NCPUS      per-CPU stall; low exactly on the cycle iload[i] is valid
// - iload        out  NCPUS*32   per-CPU returned instruction word
// - dbusy        in   1          data side owns the RAM this cycle; blocks new instruction grants
// - iinval       in   1          invalidate the line buffer (ignored unless IMEM_LINEBUF_EN)
// - ramREN       out  1          RAM read enable
// - ramaddr      out  32         RAM address
// - ramload      in   32         RAM read data
// - ramstate     in   2          FREE=0, BUSY=1, ACCESS=2, ERROR=3
// - err_timeout  out  1          one-cycle pulse when the watchdog expires
// BEHAVIOUR
// - Reset values:
//   - state IDLE; rr_ptr 0
//   - iwait all 1; iload all 0
//   - ramREN 0; ramaddr 0; err_timeout 0
// - FSM states: IDLE, REQ, BHIT (BHIT exists only with the macro).
// - IDLE:
//   - If dbusy=0 and |iREN, select the first set iREN bit scanning up from rr_ptr, wrapping at NCPUS.
//   - Register the grant index g and the address iaddr[g]; go to REQ.
//   - If dbusy=1, make no grant and stay in IDLE.
// - REQ:
//   - ramREN=1, ramaddr=latched address; watchdog counter increments every cycle.
//   - ramstate==ACCESS: combinationally drive iload[g]=ramload and iwait[g]=0 that cycle.
//     Then rr_ptr<=(g+1)%NCPUS and return to IDLE.
//   - ramstate BUSY, FREE or ERROR: hold in REQ. ERROR is retried, never returned to the CPU.
//   - iREN[g] drops mid-REQ: abort, return to IDLE, no response, rr_ptr unchanged.
//   - dbusy is ignored once granted; an in-flight fetch always completes.
//   - Counter reaches TIMEOUT (TIMEOUT!=0): pulse err_timeout for 1 cycle, abort to IDLE.
//     iREN[g] still high is re-arbitrated normally.
// - Non-granted requesters see iwait=1 continuously; iload of non-responding ports holds its last value.
// - Latency: minimum 2 cycles from iREN rise to iwait low (1 cycle IDLE grant, then REQ with ACCESS).
// - Fairness: with all NCPUS requesting, each is served once per NCPUS grants.
// - Simultaneous iREN on multiple ports: the lowest index at or after rr_ptr wins.
// - iREN held high after service re-requests normally; there is no lockout.
// - Async reset mid-REQ: ramREN drops immediately; the transaction is lost.
// CONFIGURATION
// - IMEM_LINEBUF_EN defined:
//   - One-entry buffer {valid, addr, data}, loaded on every ACCESS completion.
//   - In IDLE, a grant whose address equals a valid buffer addr goes to BHIT instead of REQ,
//     and no RAM access occurs.
//   - BHIT: iwait[g]=0, iload[g]=buffer data; advance rr_ptr; return to IDLE.
//   - A granted BHIT completes even if iREN[g] drops in BHIT.
//   - iinval=1 clears valid. If iinval and a load occur in the same cycle, the invalidate wins.
//   - dbusy still blocks grants in IDLE.
// - IMEM_LINEBUF_EN undefined: no buffer, no BHIT state; iinval unused; every fetch uses RAM.
// TESTING
// - Single fetch: CPU0 iREN, iaddr=0x40; ACCESS on the 2nd cycle with ramload=0x8C010004
//   -> iwait[0]=0 for 1 cycle, iload[0]=0x8C010004, ramaddr=0x40.
// - Contention: CPU0 and CPU1 request together, rr_ptr=0
//   -> CPU0 served first, then CPU1; repeating this gives alternating order.
// - dbusy=1 for 5 cycles with CPU1 requesting -> ramREN stays 0; grant on the first cycle dbusy=0.
// - BUSY for 3 cycles then ACCESS -> iwait[g] stays 1 through BUSY, drops only on ACCESS.
//   ERROR then ACCESS -> retried, single response.
// - TIMEOUT=4, ramstate stuck BUSY -> err_timeout pulses once after 4 REQ cycles; FSM returns to IDLE.
// - LINEBUF_EN: fetch 0x80 twice -> 2nd completes via BHIT with ramREN=0.
//   Assert iinval and repeat -> RAM accessed again.

Source files
------------

// File: rtl/imem_arbiter.sv
// imem_arbiter: round-robin instruction-fetch arbiter onto one shared RAM port.
// Define IMEM_LINEBUF_EN to add a one-entry fetch line buffer (BHIT path).
module imem_arbiter #(
  parameter int NCPUS   = 2,
  parameter int TIMEOUT = 255
) (
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic [NCPUS-1:0]      iREN,
  input  logic [NCPUS*32-1:0]   iaddr,
  output logic [NCPUS-1:0]      iwait,
  output logic [NCPUS*32-1:0]   iload,
  input  logic                  dbusy,
  input  logic                  iinval,
  output logic                  ramREN,
  output logic [31:0]           ramaddr,
  input  logic [31:0]           ramload,
  input  logic [1:0]            ramstate,
  output logic                  err_timeout
);

  localparam int IW = (NCPUS > 1) ? $clog2(NCPUS) : 1;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TLAST =
    (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
  localparam logic [1:0] ACCESS = 2'd2;

`ifdef IMEM_LINEBUF_EN
  typedef enum logic [1:0] {IDLE, REQ, BHIT} state_t;
`else
  typedef enum logic [1:0] {IDLE, REQ} state_t;
`endif

  state_t              state;
  logic [IW-1:0]       rr_ptr;
  logic [IW-1:0]       g;
  logic [IW-1:0]       pick;
  logic [IW-1:0]       g_next;
  logic                found;
  logic [31:0]         addr_q;
  logic [31:0]         pick_addr;
  logic [CW-1:0]       cnt;
  logic [NCPUS*32-1:0] held;
  logic                rsp;

`ifdef IMEM_LINEBUF_EN
  logic        buf_valid;
  logic [31:0] buf_addr;
  logic [31:0] buf_data;
  logic        hit;
  assign hit = buf_valid && (buf_addr == pick_addr);
`else
  logic unused_iinval;
  assign unused_iinval = iinval;
`endif

  assign ramaddr   = addr_q;
  assign pick_addr = iaddr[32*int'(pick) +: 32];
  assign g_next    = (int'(g) == NCPUS - 1) ? '0 : g + 1'b1;
  assign rsp       = (state == REQ) && iREN[g] && (ramstate == ACCESS);

  // first requester at or after rr_ptr, wrapping
  always_comb begin
    int j;
    j     = 0;
    pick  = rr_ptr;
    found = 1'b0;
    for (int k = NCPUS - 1; k >= 0; k--) begin
      j = int'(rr_ptr) + k;
      if (j >= NCPUS) j = j - NCPUS;
      if (iREN[j]) begin
        pick  = IW'(j);
        found = 1'b1;
      end
    end
  end

  // response path: RAM data or buffer data passes straight through
  always_comb begin
    iwait = '1;
    iload = held;
    if (rsp) begin
      iwait[g]                  = 1'b0;
      iload[32*int'(g) +: 32]   = ramload;
    end
`ifdef IMEM_LINEBUF_EN
    if (state == BHIT) begin
      iwait[g]                  = 1'b0;
      iload[32*int'(g) +: 32]   = buf_data;
    end
`endif
  end

  // grant / fetch / watchdog FSM
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      g           <= '0;
      addr_q      <= '0;
      cnt         <= '0;
      held        <= '0;
      ramREN      <= 1'b0;
      err_timeout <= 1'b0;
`ifdef IMEM_LINEBUF_EN
      buf_valid   <= 1'b0;
      buf_addr    <= '0;
      buf_data    <= '0;
`endif
    end else begin
      err_timeout <= 1'b0;
      unique case (state)
        IDLE: begin
          cnt <= '0;
          if (!dbusy && found) begin
            g      <= pick;
            addr_q <= pick_addr;
`ifdef IMEM_LINEBUF_EN
            if (hit) begin
              state <= BHIT;
            end else begin
              state  <= REQ;
              ramREN <= 1'b1;
            end
`else
            state  <= REQ;
            ramREN <= 1'b1;
`endif
          end
        end
        REQ: begin
          cnt <= cnt + 1'b1;
          if (!iREN[g]) begin
            state  <= IDLE;
            ramREN <= 1'b0;
          end else if (ramstate == ACCESS) begin
            state                   <= IDLE;
            ramREN                  <= 1'b0;
            rr_ptr                  <= g_next;
            held[32*int'(g) +: 32]  <= ramload;
`ifdef IMEM_LINEBUF_EN
            buf_valid <= 1'b1;
            buf_addr  <= addr_q;
            buf_data  <= ramload;
`endif
          end else if (TIMEOUT != 0 && cnt == TLAST) begin
            err_timeout <= 1'b1;
            state       <= IDLE;
            ramREN      <= 1'b0;
          end
        end
`ifdef IMEM_LINEBUF_EN
        BHIT: begin
          state                  <= IDLE;
          rr_ptr                 <= g_next;
          held[32*int'(g) +: 32] <= buf_data;
        end
`endif
        default: begin
          state  <= IDLE;
          ramREN <= 1'b0;
        end
      endcase
`ifdef IMEM_LINEBUF_EN
      if (iinval) buf_valid <= 1'b0;
`endif
    end
  end

endmodule

// File: tb/tb_imem_arbiter.sv
// tb_imem_arbiter: scoreboard bench for the instruction-fetch arbiter.
// Directed protocol cases, then randomized traffic against a RAM model.
module tb_imem_arbiter;
  localparam int N  = 3;
  localparam int TO = 4;
  localparam logic [1:0] FREE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] ACC  = 2'd2;
  localparam logic [1:0] ERR  = 2'd3;

  logic            CLK = 1'b0;
  logic            nRST = 1'b0;
  logic [N-1:0]    iREN = '0;
  logic [N*32-1:0] iaddr = '0;
  logic [N-1:0]    iwait;
  logic [N*32-1:0] iload;
  logic            dbusy = 1'b0;
  logic            iinval = 1'b0;
  logic            ramREN;
  logic [31:0]     ramaddr;
  logic [31:0]     ramload = '0;
  logic [1:0]      ramstate = FREE;
  logic            err_timeout;

  imem_arbiter #(.NCPUS(N), .TIMEOUT(TO)) dut (
    .CLK(CLK), .nRST(nRST), .iREN(iREN), .iaddr(iaddr),
    .iwait(iwait), .iload(iload), .dbusy(dbusy), .iinval(iinval),
    .ramREN(ramREN), .ramaddr(ramaddr), .ramload(ramload),
    .ramstate(ramstate), .err_timeout(err_timeout)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int fails  = 0;
  int err_seen = 0;
  logic [31:0] exp_q[N][$];
  int served_log[$];
  logic [N-1:0] pend = '0;
  logic [N-1:0] s_wait;
  logic s_ren, s_err;
  logic [31:0] s_addr;
  bit lat_rand = 1'b0;
  int lat_fix = 0;
  logic [1:0] ws_fix = BUSY;

  function automatic logic [31:0] mem(input logic [31:0] a);
    if (a == 32'h40) return 32'h8C01_0004;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // RAM model: ACCESS after a per-transaction number of wait cycles
  task automatic responder();
    int c = 0;
    int lat = 0;
    logic [1:0] ws = BUSY;
    forever begin
      @(posedge CLK);
      #1;
      if (ramREN) begin
        if (c == 0) begin
          if (lat_rand) begin
            lat = $urandom_range(0, 2);
            ws  = 2'($urandom_range(0, 3));
            if (ws == ACC) ws = BUSY;
          end else begin
            lat = lat_fix;
            ws  = ws_fix;
          end
        end
        if (c == lat) begin
          ramstate = ACC;
          ramload  = mem(ramaddr);
          c = 0;
        end else begin
          ramstate = ws;
          ramload  = $urandom;
          c++;
        end
      end else begin
        ramstate = FREE;
        ramload  = $urandom;
        c = 0;
      end
    end
  endtask

  // pops expected words on every response; checks holding and fairness
  task automatic monitor();
    int wc[N];
    logic [31:0] last[N];
    int nlow;
    for (int i = 0; i < N; i++) begin
      wc[i] = 0;
      last[i] = '0;
    end
    forever begin
      @(negedge CLK);
      if (!nRST) begin
        for (int i = 0; i < N; i++) begin
          wc[i] = 0;
          last[i] = '0;
        end
        continue;
      end
      if (err_timeout) err_seen++;
      nlow = 0;
      for (int i = 0; i < N; i++) if (!iwait[i]) nlow++;
      if (nlow > 0) chk("one_resp", 32'(nlow), 32'd1);
      for (int i = 0; i < N; i++) begin
        if (!iwait[i]) begin
          served_log.push_back(i);
          if (exp_q[i].size() == 0) begin
            checks++;
            fails++;
            $display("FAIL unexpected_resp cpu%0d: got %h expected none",
                     i, iload[i*32 +: 32]);
          end else begin
            chk($sformatf("iload%0d", i), iload[i*32 +: 32],
                exp_q[i].pop_front());
          end
          last[i] = iload[i*32 +: 32];
          for (int j = 0; j < N; j++) begin
            if (j != i && iREN[j]) begin
              wc[j]++;
              chk($sformatf("fair%0d", j), 32'(wc[j] <= N - 1), 32'd1);
            end
          end
          wc[i] = 0;
        end else begin
          chk($sformatf("hold%0d", i), iload[i*32 +: 32], last[i]);
        end
      end
      for (int i = 0; i < N; i++) if (!iREN[i]) wc[i] = 0;
    end
  endtask

  task automatic step();
    @(negedge CLK);
    s_wait = iwait;
    s_ren  = ramREN;
    s_addr = ramaddr;
    s_err  = err_timeout;
    @(posedge CLK);
    #1;
    for (int i = 0; i < N; i++) begin
      if (pend[i] && !s_wait[i]) begin
        pend[i] = 1'b0;
        iREN[i] = 1'b0;
      end
    end
  endtask

  task automatic issue(input int i, input logic [31:0] a);
    iREN[i] = 1'b1;
    iaddr[i*32 +: 32] = a;
    pend[i] = 1'b1;
    exp_q[i].push_back(mem(a));
  endtask

  task automatic wait_done(input int bound, output int k);
    k = 0;
    while (|pend && k < bound) begin
      step();
      k++;
    end
    if (|pend) begin
      checks++;
      fails++;
      $display("FAIL wait_done: pending %b after %0d cycles, required 0",
               pend, bound);
      iREN = '0;
      pend = '0;
      for (int i = 0; i < N; i++) exp_q[i].delete();
    end
  endtask

  task automatic chk_order(input string nm, input int e[$]);
    chk({nm, "_n"}, 32'(served_log.size()), 32'(e.size()));
    for (int k = 0; k < e.size() && k < served_log.size(); k++)
      chk($sformatf("%s_%0d", nm, k), 32'(served_log[k]), 32'(e[k]));
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int k, e0, nr;
    bit got;
    fork
      monitor();
      responder();
    join_none

    repeat (2) @(posedge CLK);
    #1;
    chk("rst_iwait", 32'(iwait), 32'(3'b111));
    chk("rst_iload", iload[31:0] | iload[63:32] | iload[95:64], 32'd0);
    chk("rst_ramREN", 32'(ramREN), 32'd0);
    chk("rst_ramaddr", ramaddr, 32'd0);
    chk("rst_err", 32'(err_timeout), 32'd0);
    nRST = 1'b1;
    step();

    served_log.delete();
    repeat (2) begin
      issue(0, 32'h100);
      issue(1, 32'h104);
      wait_done(20, k);
    end
    chk_order("contend", '{0, 1, 0, 1});

    issue(0, 32'h40);
    wait_done(10, k);
    chk("single_lat", 32'(k), 32'd2);
    chk("single_ren", 32'(s_ren), 32'd1);
    chk("single_addr", s_addr, 32'h40);

    dbusy = 1'b1;
    issue(1, 32'h200);
    repeat (5) begin
      step();
      chk("dbusy_ren", 32'(s_ren), 32'd0);
    end
    dbusy = 1'b0;
    wait_done(10, k);
    chk("dbusy_lat", 32'(k), 32'd2);

    lat_fix = 3;
    ws_fix = BUSY;
    issue(0, 32'h300);
    wait_done(20, k);
    chk("busy3_lat", 32'(k), 32'd5);

    lat_fix = 1;
    ws_fix = ERR;
    issue(0, 32'h304);
    wait_done(20, k);
    chk("err_retry_lat", 32'(k), 32'd3);

    lat_fix = 100;
    ws_fix = BUSY;
    e0 = err_seen;
    issue(2, 32'h400);
    nr = 0;
    got = 1'b0;
    for (int c = 0; c < 12 && !got; c++) begin
      step();
      if (s_err) got = 1'b1;
      else if (s_ren) nr++;
    end
    chk("to_seen", 32'(got), 32'd1);
    chk("to_req_cycles", 32'(nr), 32'd4);
    chk("to_idle", 32'(s_ren), 32'd0);
    iREN[2] = 1'b0;
    pend[2] = 1'b0;
    void'(exp_q[2].pop_back());
    repeat (6) step();
    chk("to_once", 32'(err_seen - e0), 32'd1);

    e0 = err_seen;
    issue(1, 32'h500);
    repeat (2) step();
    iREN[1] = 1'b0;
    pend[1] = 1'b0;
    void'(exp_q[1].pop_back());
    repeat (3) step();
    chk("abort_noerr", 32'(err_seen - e0), 32'd0);
    chk("abort_idle", 32'(s_ren), 32'd0);

    lat_fix = 0;
    served_log.delete();
    issue(0, 32'h600);
    issue(1, 32'h604);
    issue(2, 32'h608);
    wait_done(20, k);
    chk_order("rr_after_abort", '{1, 2, 0});

`ifdef IMEM_LINEBUF_EN
    issue(0, 32'h80);
    wait_done(10, k);
    issue(0, 32'h80);
    nr = 0;
    for (int c = 0; c < 10 && pend[0]; c++) begin
      step();
      if (s_ren) nr++;
    end
    chk("bhit_no_ram", 32'(nr), 32'd0);
    chk("bhit_done", 32'(pend[0]), 32'd0);
    iinval = 1'b1;
    step();
    iinval = 1'b0;
    issue(0, 32'h80);
    nr = 0;
    for (int c = 0; c < 10 && pend[0]; c++) begin
      step();
      if (s_ren) nr++;
    end
    chk("inval_ram", 32'(nr != 0), 32'd1);
    chk("inval_done", 32'(pend[0]), 32'd0);
`endif

    lat_fix = 100;
    issue(0, 32'h700);
    repeat (2) step();
    #2;
    chk("pre_rst_ren", 32'(ramREN), 32'd1);
    nRST = 1'b0;
    #1;
    chk("async_rst_ren", 32'(ramREN), 32'd0);
    chk("async_rst_iwait", 32'(iwait), 32'(3'b111));
    iREN = '0;
    pend = '0;
    for (int i = 0; i < N; i++) exp_q[i].delete();
    @(posedge CLK);
    #1;
    nRST = 1'b1;
    step();

    lat_fix = 0;
    lat_rand = 1'b1;
    e0 = err_seen;
    repeat (600) begin
      step();
      dbusy = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < N; i++)
        if (!pend[i] && $urandom_range(0, 2) == 0)
          issue(i, 32'h1000 | (32'($urandom_range(0, 15)) << 2));
    end
    dbusy = 1'b0;
    wait_done(60, k);
    repeat (2) step();
    chk("rand_drain", 32'(exp_q[0].size() + exp_q[1].size()
                          + exp_q[2].size()), 32'd0);
    chk("rand_no_timeout", 32'(err_seen - e0), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end
endmodule
